// File: rtl/hilo_unit_if.sv
// Bus between the EX stage / multiplier and the HI/LO register pair.
// mul_done qualifies mul_out for exactly one cycle; rd_valid qualifies rd_data for one cycle; neither side can backpressure.
interface hilo_unit_if;
  logic [5:0]  Signal;
  logic [31:0] wr_data;
  logic [63:0] mul_out;
  logic        mul_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        busy;
  logic        err;
  logic [1:0]  state_dbg;

  modport master (
    output Signal, wr_data, mul_out, mul_done,
    input  hi, lo, rd_data, rd_valid, stall, busy, err, state_dbg
  );

  modport slave (
    input  Signal, wr_data, mul_out, mul_done,
    output hi, lo, rd_data, rd_valid, stall, busy, err, state_dbg
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register pair: captures the multiplier product, serves MFHI/MFLO/MTHI/MTLO,
// stalls the pipeline during MULTU and raises a sticky error if the multiplier never finishes.
module hilo_unit #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  hilo_unit_if.slave  bus
);
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);
  localparam logic [5:0] CNT_MAX  = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01
  } state_t;

  state_t      state, next_state;
  logic [5:0]  cnt;
  logic [31:0] hi_q, lo_q, rd_data_q;
  logic        rd_valid_q, err_q;
  logic        busy_c, stall_c, idle_c, start_c, capture_c, timeout_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Done beats timeout, timeout beats abort; all three leave WAIT.
  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    stall_c    = 1'b0;
    idle_c     = 1'b0;
    start_c    = 1'b0;
    capture_c  = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      IDLE: begin
        idle_c = 1'b1;
        if (bus.Signal == F_MULTU) begin
          next_state = WAIT;
          start_c    = 1'b1;
        end
      end
      WAIT: begin
        busy_c  = 1'b1;
        stall_c = ~bus.mul_done;
        if (bus.mul_done) begin
          capture_c  = 1'b1;
          next_state = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_c  = 1'b1;
          next_state = IDLE;
        end else if (bus.Signal != F_MULTU) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      if (start_c)
        cnt <= '0;
      else if (busy_c && cnt != CNT_MAX)
        cnt <= cnt + 6'd1;
      if (timeout_c)
        err_q <= 1'b1;
      if (capture_c) begin
        hi_q <= bus.mul_out[63:32];
        lo_q <= bus.mul_out[31:0];
      end
      if (idle_c) begin
        case (bus.Signal)
          F_MFHI: begin
            rd_data_q  <= hi_q;
            rd_valid_q <= 1'b1;
          end
          F_MFLO: begin
            rd_data_q  <= lo_q;
            rd_valid_q <= 1'b1;
          end
          F_MTHI:  hi_q <= bus.wr_data;
          F_MTLO:  lo_q <= bus.wr_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.stall     = stall_c;
  assign bus.busy      = busy_c;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: capture, reads, writes, abort, watchdog and reset mid-WAIT.
module tb_hilo_unit;
  localparam logic [5:0] F_NOP   = 6'b000000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hilo_unit_if bus ();

  hilo_unit #(.TIMEOUT(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.Signal   = F_NOP;
    bus.wr_data  = '0;
    bus.mul_out  = '0;
    bus.mul_done = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.hi, bus.lo, bus.rd_data} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: hi=%h lo=%h rd=%h required all 0", bus.hi, bus.lo, bus.rd_data);
    end
    checks++;
    if ({bus.rd_valid, bus.stall, bus.busy, bus.err, bus.state_dbg} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: v/s/b/e/st=%b required 000000",
               {bus.rd_valid, bus.stall, bus.busy, bus.err, bus.state_dbg});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu_capture();
    int stall_cycles;
    stall_cycles = 0;
    bus.Signal = F_MULTU;
    tick();
    checks++;
    if (bus.state_dbg !== 2'b01 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL enter_wait: state=%b busy=%b required 01/1", bus.state_dbg, bus.busy);
    end
    for (int i = 0; i < 33; i++) begin
      if (bus.stall === 1'b1) stall_cycles++;
      tick();
    end
    checks++;
    if (stall_cycles != 33) begin
      failures++;
      $display("FAIL stall_len: got %0d cycles required 33", stall_cycles);
    end
    bus.mul_done = 1'b1;
    bus.mul_out  = 64'h0000_0001_FFFF_FFFE;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_on_done: stall=%b busy=%b required 0/1", bus.stall, bus.busy);
    end
    @(posedge clk);
    #1;
    bus.mul_done = 1'b0;
    bus.Signal   = F_NOP;
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL capture: hi=%h lo=%h required 00000001/fffffffe", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL post_capture: busy=%b stall=%b err=%b required 0/0/0", bus.busy, bus.stall, bus.err);
    end
  endtask

  task automatic test_back_to_back_reads();
    bus.Signal = F_MFHI;
    tick();
    bus.Signal = F_MFLO;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h1) begin
      failures++;
      $display("FAIL mfhi: valid=%b rd=%h required 1/00000001", bus.rd_valid, bus.rd_data);
    end
    tick();
    bus.Signal = F_NOP;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mflo: valid=%b rd=%h required 1/fffffffe", bus.rd_valid, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_pulse: valid=%b required 0", bus.rd_valid);
    end
  endtask

  task automatic test_mtlo();
    bus.Signal  = F_MTLO;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.Signal  = F_MFLO;
    bus.wr_data = '0;
    checks++;
    if (bus.lo !== 32'hDEAD_BEEF || bus.hi !== 32'h1) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h required 00000001/deadbeef", bus.hi, bus.lo);
    end
    tick();
    bus.Signal = F_NOP;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mflo_after_mtlo: valid=%b rd=%h required 1/deadbeef", bus.rd_valid, bus.rd_data);
    end
    bus.mul_done = 1'b1;
    bus.mul_out  = 64'h1234_5678_9ABC_DEF0;
    tick();
    bus.mul_done = 1'b0;
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hDEAD_BEEF || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_in_idle: hi=%h lo=%h busy=%b required 00000001/deadbeef/0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_abort();
    bus.Signal = F_MULTU;
    tick();
    for (int i = 0; i < 10; i++) tick();
    bus.Signal = F_NOP;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_cycle: stall=%b busy=%b required 1/1", bus.stall, bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.state_dbg !== 2'b00) begin
      failures++;
      $display("FAIL abort_idle: busy=%b stall=%b state=%b required 0/0/00", bus.busy, bus.stall, bus.state_dbg);
    end
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hDEAD_BEEF || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold: hi=%h lo=%h err=%b required 00000001/deadbeef/0", bus.hi, bus.lo, bus.err);
    end
  endtask

  task automatic test_timeout();
    int early_err;
    early_err = 0;
    bus.Signal = F_MULTU;
    tick();
    for (int i = 0; i < 39; i++) begin
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) early_err++;
      tick();
    end
    checks++;
    if (early_err != 0) begin
      failures++;
      $display("FAIL timeout_early: %0d bad cycles required 0", early_err);
    end
    tick();
    bus.Signal = F_NOP;
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL timeout: err=%b busy=%b stall=%b required 1/0/0", bus.err, bus.busy, bus.stall);
    end
    checks++;
    if (bus.hi !== 32'h1 || bus.lo !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL timeout_hold: hi=%h lo=%h required 00000001/deadbeef", bus.hi, bus.lo);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b required 1", bus.err);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.Signal = F_MULTU;
    tick();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.hi, bus.lo, bus.rd_data} !== 96'h0) begin
      failures++;
      $display("FAIL async_reset_data: hi=%h lo=%h rd=%h required all 0", bus.hi, bus.lo, bus.rd_data);
    end
    checks++;
    if ({bus.rd_valid, bus.stall, bus.busy, bus.err, bus.state_dbg} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset_ctrl: v/s/b/e/st=%b required 000000",
               {bus.rd_valid, bus.stall, bus.busy, bus.err, bus.state_dbg});
    end
    bus.Signal = F_NOP;
    tick();
    reset        = 1'b0;
    bus.mul_done = 1'b1;
    bus.mul_out  = 64'hAAAA_5555_1234_4321;
    tick();
    bus.mul_done = 1'b0;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_after_reset: hi=%h lo=%h busy=%b required 0/0/0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    #1;
    test_reset();
    test_multu_capture();
    test_back_to_back_reads();
    test_mtlo();
    test_abort();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
